// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin scheduler sharing one UART transmitter
//
// Grants one requester per frame, loads the transmitter's holding and status
// words, times the frame by counting bit ticks and acks the winner.
//
// Ports:
//   the_new_generated_clock       clock shared with the transmitter
//   reset                         synchronous, active-high
//   sampling_pulse[3:0]           transmitter sampling bus; 4'b1000 = bit boundary
//   cfg_data_bits/parity/stop     frame format, captured at arbitration
//   req_valid[NUM_REQ]            per-requester request, held until ack
//   req_data[NUM_REQ*DATA_W]      payloads, requester i owns [i*DATA_W +: DATA_W]
//   req_grant[NUM_REQ]            one-hot current owner, 0 when idle
//   req_ack[NUM_REQ]              one-cycle pulse at frame end
//   req_err                       one-cycle pulse with ack on a rejected config
//   busy                          high from LOAD through DONE
//   Transmitter_Holding_Register  {0, payload masked to data bits}
//   Transmitter_Status            {24'b0, stop, parity, data_bits, STA_TX}
module uart_tx_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 9
) (
  input  logic                      the_new_generated_clock,
  input  logic                      reset,
  input  logic [3:0]                sampling_pulse,
  input  logic [3:0]                cfg_data_bits,
  input  logic                      cfg_parity,
  input  logic [1:0]                cfg_stop,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_grant,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic                      req_err,
  output logic                      busy,
  output logic [31:0]               Transmitter_Holding_Register,
  output logic [31:0]               Transmitter_Status
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_LOAD,
    S_SEND,
    S_DONE
  } state_t;

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   winner;
  logic [3:0]         sp_prev;
  logic [4:0]         tick_cnt;
  logic [4:0]         frame_bits;
  logic [3:0]         cap_data_bits;
  logic               cap_parity;
  logic [1:0]         cap_stop;

  logic               tick;
  logic               cfg_legal;
  logic               arb_found;
  logic [PTR_W-1:0]   arb_idx;
  logic [NUM_REQ-1:0] arb_onehot;
  int                 scan;
  logic [DATA_W-1:0]  win_payload;
  logic [DATA_W-1:0]  masked_payload;

  // Edge-detect the bit boundary so a held 4'b1000 yields a single tick.
  assign tick = (sampling_pulse == 4'b1000) && (sp_prev != 4'b1000);

  assign cfg_legal = (cfg_data_bits >= 4'd5) && (cfg_data_bits <= 4'd9) &&
                     ((cfg_stop == 2'd1) || (cfg_stop == 2'd2));

  // First asserted request at or after rr_ptr, wrapping around.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    scan      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = int'(rr_ptr) + k;
      if (scan >= NUM_REQ) scan = scan - NUM_REQ;
      if (!arb_found && req_valid[PTR_W'(scan)]) begin
        arb_found = 1'b1;
        arb_idx   = PTR_W'(scan);
      end
    end
  end

  always_comb begin
    arb_onehot          = '0;
    arb_onehot[arb_idx] = 1'b1;
  end

  // Payload bits beyond the configured length never reach the transmitter.
  always_comb begin
    win_payload    = req_data[int'(winner)*DATA_W +: DATA_W];
    masked_payload = '0;
    for (int i = 0; i < DATA_W; i++) begin
      masked_payload[i] = win_payload[i] && (i < int'(cap_data_bits));
    end
  end

  always_ff @(posedge the_new_generated_clock) begin
    if (reset) begin
      state                        <= S_IDLE;
      rr_ptr                       <= '0;
      winner                       <= '0;
      sp_prev                      <= '0;
      tick_cnt                     <= '0;
      frame_bits                   <= '0;
      cap_data_bits                <= '0;
      cap_parity                   <= 1'b0;
      cap_stop                     <= '0;
      req_grant                    <= '0;
      req_ack                      <= '0;
      req_err                      <= 1'b0;
      busy                         <= 1'b0;
      Transmitter_Holding_Register <= '0;
      Transmitter_Status           <= '0;
    end else begin
      sp_prev <= sampling_pulse;
      req_ack <= '0;
      req_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|req_valid) state <= S_ARB;
        end
        S_ARB: begin
          if (!arb_found) begin
            // Request withdrawn before arbitration; nothing to serve.
            state <= S_IDLE;
          end else begin
            winner        <= arb_idx;
            req_grant     <= arb_onehot;
            cap_data_bits <= cfg_data_bits;
            cap_parity    <= cfg_parity;
            cap_stop      <= cfg_stop;
            frame_bits    <= 5'd1 + 5'(cfg_data_bits) + 5'(cfg_parity) + 5'(cfg_stop);
            if (cfg_legal) begin
              busy  <= 1'b1;
              state <= S_LOAD;
            end else begin
              // Rejected format: skip the transmitter and ack with error.
              req_ack <= arb_onehot;
              req_err <= 1'b1;
              state   <= S_DONE;
            end
          end
        end
        S_LOAD: begin
          Transmitter_Holding_Register <= 32'(masked_payload);
          Transmitter_Status <= {24'b0, cap_stop, cap_parity, cap_data_bits, 1'b1};
          tick_cnt <= '0;
          state    <= S_SEND;
        end
        S_SEND: begin
          // First tick aligns the start bit, so the frame ends on tick frame_bits+1.
          if (tick) begin
            if (tick_cnt == frame_bits) begin
              Transmitter_Status[0] <= 1'b0;
              req_ack               <= req_grant;
              state                 <= S_DONE;
            end else begin
              tick_cnt <= tick_cnt + 5'd1;
            end
          end
        end
        S_DONE: begin
          req_grant <= '0;
          busy      <= 1'b0;
          rr_ptr    <= (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + PTR_W'(1);
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
